// File: rtl/nonrestoring_divider_if.sv
// Purpose : start/done handshake and operand/result bundle for the sequential
//           non-restoring divider.
// Ports   : master drives start/dividend/divisor and observes the results;
//           slave (the divider) samples the request and drives quotient,
//           remainder, busy, done and dbz.
interface nonrestoring_divider_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             busy;
  logic             done;
  logic             dbz;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, busy, done, dbz
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, busy, done, dbz
  );
endinterface

// File: rtl/nonrestoring_divider.sv
// Purpose : 16-bit unsigned sequential non-restoring divider (controller and
//           datapath in one module), start/done handshake.
// Latency : done pulses 18 clocks after the accepted start (1 clock for a zero
//           divisor); a new start can be taken every 19 clocks.
// Backpressure: none; start is only sampled in IDLE and ignored while busy.
// Ports   : clk    - rising-edge clock
//           reset  - asynchronous, active-high; aborts any divide silently
//           bus    - slave side of nonrestoring_divider_if:
//                    start/dividend/divisor in, quotient/remainder/busy/done/dbz
//                    out (all outputs registered).
module nonrestoring_divider #(
  parameter int WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  nonrestoring_divider_if.slave bus
);

  // Iteration count; the counter is 5 bits wide so WIDTH must stay at 16.
  localparam logic [4:0] CNT_LOAD = 5'(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_m;         // captured divisor
  logic [WIDTH:0]   r_a;         // signed partial remainder, one guard bit
  logic [WIDTH-1:0] r_q;         // dividend shifting out, quotient shifting in
  logic [4:0]       r_cnt;       // iterations remaining

  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_busy;
  logic             r_done;
  logic             r_dbz;

  logic [WIDTH:0]   w_m_ext;
  logic [WIDTH:0]   w_shift_a;
  logic [WIDTH:0]   w_calc_a;
  logic [WIDTH:0]   w_fix_a;
  logic             w_div_zero;

  assign w_m_ext   = {1'b0, r_m};

  // Upper half of {A,Q} << 1: A loses its sign bit, gains the top dividend bit.
  assign w_shift_a = {r_a[WIDTH-1:0], r_q[WIDTH-1]};

  // Non-restoring step: the sign of the previous partial remainder picks
  // subtract (non-negative) or add back (negative) instead of a restore cycle.
  assign w_calc_a  = r_a[WIDTH] ? (w_shift_a + w_m_ext) : (w_shift_a - w_m_ext);

  // Final correction so the remainder ends non-negative.
  assign w_fix_a   = r_a + w_m_ext;

  // M only stays zero into DONE when the zero-divisor shortcut was taken.
  assign w_div_zero = (r_m == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_m         <= '0;
      r_a         <= '0;
      r_q         <= '0;
      r_cnt       <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_dbz       <= 1'b0;
    end else begin
      // done is a single-cycle pulse; only DONE raises it.
      r_done <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_m     <= bus.divisor;
            r_q     <= bus.dividend;
            r_a     <= '0;
            r_cnt   <= CNT_LOAD;
            r_busy  <= 1'b1;
            r_dbz   <= 1'b0;
            // A zero divisor skips the iterations entirely.
            r_state <= (bus.divisor == '0) ? S_DONE : S_CALC;
          end
        end

        S_CALC: begin
          r_a   <= w_calc_a;
          r_q   <= {r_q[WIDTH-2:0], ~w_calc_a[WIDTH]};
          r_cnt <= r_cnt - 5'd1;
          if (r_cnt == 5'd1) begin
            r_state <= S_FIX;
          end
        end

        S_FIX: begin
          if (r_a[WIDTH]) begin
            r_a <= w_fix_a;
          end
          r_state <= S_DONE;
        end

        S_DONE: begin
          if (w_div_zero) begin
            r_quotient  <= '1;
            r_remainder <= r_q;          // untouched dividend
            r_dbz       <= 1'b1;
          end else begin
            r_quotient  <= r_q;
            r_remainder <= r_a[WIDTH-1:0];
            r_dbz       <= 1'b0;
          end
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.quotient  = r_quotient;
  assign bus.remainder = r_remainder;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.dbz       = r_dbz;

endmodule
